// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// instruction opcodes and the ALUOp values seen by the ALU control decoder.
package mips_ctrl_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ADDIWB = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_FUNCT = 4'b0010;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: Moore decode of the state
// register into mux selects and write strobes, with mem_ready stalls.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] state_q, state_d;
    logic       is_sw_q;
    logic       pc_en_c, ir_write_c, mem_write_c, reg_write_c, illegal_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Opcode is only looked at in DECODE; remember the LW/SW split for MEMADR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   is_sw_q <= 1'b0;
        else if (state_q == S_DECODE) is_sw_q <= (opcode == OP_SW);
    end

    always_comb begin
        state_d     = state_q;
        alu_op      = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        pc_en_c     = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                pc_en_c    = mem_ready;
                ir_write_c = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = is_sw_q ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                pc_en_c   = zero;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en_c = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked by rst_n directly so none can rise while reset is held.
    assign pc_en      = pc_en_c     & rst_n;
    assign ir_write   = ir_write_c  & rst_n;
    assign mem_write  = mem_write_c & rst_n;
    assign reg_write  = reg_write_c & rst_n;
    assign illegal_op = illegal_c   & rst_n;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver queues the expected
// state and control word per cycle, a monitor pops and compares them.
module tb_multicycle_control;

    logic       clk, rst_n, zero, mem_ready;
    logic [5:0] opcode;
    logic [3:0] alu_op, state;
    logic       alu_src_a, pc_en, iord, ir_write, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, illegal_op;
    logic [1:0] alu_src_b, pc_src;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_en(pc_en), .iord(iord), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word: alu_op, src_a, src_b, pc_src, then
    // pc_en, iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg, illegal_op.
    localparam logic [16:0] C_FRDY  = {4'b0000, 1'b0, 2'b01, 2'b00, 8'b1010_0000};
    localparam logic [16:0] C_FWAIT = {4'b0000, 1'b0, 2'b01, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_DEC   = {4'b0000, 1'b0, 2'b11, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_DECIL = {4'b0000, 1'b0, 2'b11, 2'b00, 8'b0000_0001};
    localparam logic [16:0] C_MADR  = {4'b0000, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_MRD   = {4'b0000, 1'b0, 2'b00, 2'b00, 8'b0100_0000};
    localparam logic [16:0] C_MWB   = {4'b0000, 1'b0, 2'b00, 2'b00, 8'b0000_1010};
    localparam logic [16:0] C_MWR   = {4'b0000, 1'b0, 2'b00, 2'b00, 8'b0101_0000};
    localparam logic [16:0] C_EXEC  = {4'b0010, 1'b1, 2'b00, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_AWB   = {4'b0000, 1'b0, 2'b00, 2'b00, 8'b0000_1100};
    localparam logic [16:0] C_BR1   = {4'b0001, 1'b1, 2'b00, 2'b01, 8'b1000_0000};
    localparam logic [16:0] C_BR0   = {4'b0001, 1'b1, 2'b00, 2'b01, 8'b0000_0000};
    localparam logic [16:0] C_AEX   = {4'b0000, 1'b1, 2'b10, 2'b00, 8'b0000_0000};
    localparam logic [16:0] C_IWB   = {4'b0000, 1'b0, 2'b00, 2'b00, 8'b0000_1000};
    localparam logic [16:0] C_JMP   = {4'b0000, 1'b0, 2'b00, 2'b10, 8'b1000_0000};

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010, IL = 6'b111111;

    logic [20:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;

    // Monitor: compares one queued expectation shortly after each falling clock
    // edge, and also right after an asynchronous reset assertion.
    initial begin
        logic [20:0] exp, got;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {state, alu_op, alu_src_a, alu_src_b, pc_src, pc_en, iord, ir_write,
                       mem_write, reg_write, reg_dst, mem_to_reg, illegal_op};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL check%0d @%0t: state/ctl got %h_%h want %h_%h",
                             checks, $time, got[20:17], got[16:0], exp[20:17], exp[16:0]);
                end
            end
        end
    end

    task automatic cyc(input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [16:0] c);
        opcode = op; zero = z; mem_ready = mr;
        exp_q.push_back({st, c});
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        // In reset with mem_ready high: FETCH selects, strobes held low
        exp_q.push_back({4'd0, C_FWAIT});
        @(posedge clk); #1;
        rst_n = 1'b1;

        // R-type, mem_ready low outside FETCH must not stall
        cyc(RT, 0, 1, 4'd0, C_FRDY);
        cyc(RT, 0, 0, 4'd1, C_DEC);
        cyc(RT, 0, 0, 4'd6, C_EXEC);
        cyc(RT, 0, 0, 4'd7, C_AWB);
        // LW with two MEMRD wait cycles: 7 cycles
        cyc(LW, 0, 1, 4'd0, C_FRDY);
        cyc(LW, 0, 1, 4'd1, C_DEC);
        cyc(LW, 0, 0, 4'd2, C_MADR);
        cyc(LW, 0, 0, 4'd3, C_MRD);
        cyc(LW, 0, 0, 4'd3, C_MRD);
        cyc(LW, 0, 1, 4'd3, C_MRD);
        cyc(LW, 0, 0, 4'd4, C_MWB);
        // BEQ taken then not taken
        cyc(BQ, 0, 1, 4'd0, C_FRDY);
        cyc(BQ, 0, 1, 4'd1, C_DEC);
        cyc(BQ, 1, 1, 4'd8, C_BR1);
        cyc(BQ, 1, 1, 4'd0, C_FRDY);
        cyc(BQ, 1, 1, 4'd1, C_DEC);
        cyc(BQ, 0, 1, 4'd8, C_BR0);
        // SW with three MEMWR wait cycles
        cyc(SW, 0, 1, 4'd0, C_FRDY);
        cyc(SW, 0, 1, 4'd1, C_DEC);
        cyc(SW, 0, 1, 4'd2, C_MADR);
        cyc(SW, 0, 0, 4'd5, C_MWR);
        cyc(SW, 0, 0, 4'd5, C_MWR);
        cyc(SW, 0, 0, 4'd5, C_MWR);
        cyc(SW, 0, 1, 4'd5, C_MWR);
        // ADDI with two FETCH wait cycles
        cyc(AI, 0, 0, 4'd0, C_FWAIT);
        cyc(AI, 0, 0, 4'd0, C_FWAIT);
        cyc(AI, 0, 1, 4'd0, C_FRDY);
        cyc(AI, 0, 1, 4'd1, C_DEC);
        cyc(AI, 0, 1, 4'd9, C_AEX);
        cyc(AI, 0, 1, 4'd10, C_IWB);
        // J
        cyc(JJ, 0, 1, 4'd0, C_FRDY);
        cyc(JJ, 0, 1, 4'd1, C_DEC);
        cyc(JJ, 0, 1, 4'd11, C_JMP);
        // Illegal opcode: 2 cycles, then back in FETCH
        cyc(IL, 0, 1, 4'd0, C_FRDY);
        cyc(IL, 0, 1, 4'd1, C_DECIL);
        // R-type interrupted by reset in ALUWB
        cyc(RT, 0, 1, 4'd0, C_FRDY);
        cyc(RT, 0, 1, 4'd1, C_DEC);
        cyc(RT, 0, 1, 4'd6, C_EXEC);
        exp_q.push_back({4'd7, C_AWB});
        #6;
        exp_q.push_back({4'd0, C_FWAIT});
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back({4'd0, C_FWAIT});
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(JJ, 0, 1, 4'd0, C_FRDY);
        cyc(JJ, 0, 1, 4'd1, C_DEC);
        cyc(JJ, 0, 1, 4'd11, C_JMP);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: pending expectations got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
